// File: rtl/div_iter_pkg.sv
// Shared state encodings and constants for the iterative divider.
package div_iter_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_CALC = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] w_diff;

  // pr_i < 2*divisor, so bit WIDTH of the difference is exactly the borrow
  assign w_diff = pr_i - {1'b0, divisor_i};
  assign q_o    = ~w_diff[WIDTH];
  assign rem_o  = q_o ? w_diff[WIDTH-1:0] : pr_i[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) answering the ALU start/ready handshake.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]   w_pr;
  logic [WIDTH-1:0] w_rem;
  logic             w_q;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_sign1;
  logic             w_sign2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;

  assign w_sign1 = signed_div_i & opdata1_i[WIDTH-1];
  assign w_sign2 = signed_div_i & opdata2_i[WIDTH-1];
  assign w_abs1  = w_sign1 ? -opdata1_i : opdata1_i;
  assign w_abs2  = w_sign2 ? -opdata2_i : opdata2_i;

  // r_dvd doubles as the quotient: dividend bits shift out the top, quotient bits in the bottom
  assign w_pr   = {r_rem, r_dvd[WIDTH-1]};
  assign w_quot = {r_dvd[WIDTH-2:0], w_q};

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr_i      (w_pr),
    .divisor_i (r_dvs),
    .rem_o     (w_rem),
    .q_o       (w_q)
  );

  assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
  assign w_rem_fix  = r_neg_r ? -w_rem  : w_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        r_state <= DIV_IDLE;
      end else begin
        case (r_state)
          DIV_IDLE: begin
            if (start_i) begin
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_sign1 ^ w_sign2;
              r_neg_r <= w_sign1;
              r_state <= (opdata2_i == '0) ? DIV_ZERO : DIV_CALC;
            end
          end
          DIV_ZERO: begin
            if (!start_i) begin
              r_state <= DIV_IDLE;
            end else begin
              result_o <= '0;
              ready_o  <= 1'b1;
              r_state  <= DIV_DONE;
            end
          end
          DIV_CALC: begin
            if (!start_i) begin
              r_state <= DIV_IDLE;
            end else begin
              r_rem <= w_rem;
              r_dvd <= w_quot;
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(WIDTH - 1)) begin
                result_o <= {w_rem_fix, w_quot_fix};
                ready_o  <= 1'b1;
                r_state  <= DIV_DONE;
              end
            end
          end
          default: r_state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter with hand-computed results.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request from a negedge, holds start until ready, then samples the following cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [63:0] res,
                        output logic rdy_after, output int rdy_cyc);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat       = -1;
    res       = '0;
    rdy_after = 1'b1;
    rdy_cyc   = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ready_o) begin
        lat     = n;
        res     = result_o;
        rdy_cyc = cyc;
        break;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    rdy_after = ready_o;
    $display("div %s %08h / %08h -> %016h latency %0d", s ? "S" : "U", a, b, res, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
    checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %016h want 0", result_o); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_unsigned();
    int lat, rc; logic [63:0] res; logic ra;
    do_div(32'd100, 32'd7, 1'b0, lat, res, ra, rc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL udiv_latency got %0d want 33", lat); end
    checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL udiv_result got %016h want 000000020000000e", res); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL udiv_ready_width got %b want 0", ra); end
  endtask

  task automatic test_signed();
    int lat, rc; logic [63:0] res; logic ra;
    do_div(32'hFFFFFFF9, 32'h00000002, 1'b1, lat, res, ra, rc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL sdiv_latency got %0d want 33", lat); end
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL sdiv_result got %016h want fffffffffffffffd", res); end
  endtask

  task automatic test_wrap();
    int lat, rc; logic [63:0] res; logic ra;
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res, ra, rc);
    checks++; if (res !== 64'h00000000_80000000) begin errors++; $display("FAIL wrap_signed got %016h want 0000000080000000", res); end
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, res, ra, rc);
    checks++; if (res !== 64'h80000000_00000000) begin errors++; $display("FAIL wrap_unsigned got %016h want 8000000000000000", res); end
  endtask

  task automatic test_annul();
    int lat, rc, pulses; logic [63:0] res; logic ra;
    pulses = 0;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    annul_i = 1'b1;
    @(negedge clk);
    if (ready_o) pulses++;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL annul_no_ready got %0d pulses want 0", pulses); end
    checks++; if (result_o !== 64'h80000000_00000000) begin errors++; $display("FAIL annul_result_kept got %016h want 8000000000000000", result_o); end
    annul_i = 1'b0;
    $display("annul 1000 / 7 after 10 calc cycles");
    do_div(32'd9, 32'd3, 1'b0, lat, res, ra, rc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL annul_restart_latency got %0d want 33", lat); end
    checks++; if (res !== 64'h00000000_00000003) begin errors++; $display("FAIL annul_restart_result got %016h want 0000000000000003", res); end
  endtask

  task automatic test_zero();
    int lat, rc; logic [63:0] res; logic ra;
    do_div(32'd12345, 32'd0, 1'b1, lat, res, ra, rc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", lat); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL zero_result got %016h want 0", res); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL zero_ready_width got %b want 0", ra); end
  endtask

  task automatic test_reset_mid();
    int lat, rc; logic [63:0] res; logic ra;
    do_div(32'd7, 32'd2, 1'b0, lat, res, ra, rc);
    checks++; if (res !== 64'h00000001_00000003) begin errors++; $display("FAIL pre_rst_result got %016h want 0000000100000003", res); end
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", ready_o); end
    checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL rst_mid_result got %016h want 0", result_o); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset during 50 / 3 calc");
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, rc1, rc2; logic [63:0] res1, res2; logic ra1, ra2;
    do_div(32'd20, 32'd6, 1'b0, lat1, res1, ra1, rc1);
    do_div(32'd21, 32'd6, 1'b0, lat2, res2, ra2, rc2);
    checks++; if (res1 !== 64'h00000002_00000003) begin errors++; $display("FAIL b2b_first got %016h want 0000000200000003", res1); end
    checks++; if (res2 !== 64'h00000003_00000003) begin errors++; $display("FAIL b2b_second got %016h want 0000000300000003", res2); end
    checks++; if (lat2 !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat2); end
    checks++; if ((rc2 - rc1) !== 34) begin errors++; $display("FAIL b2b_spacing got %0d want 34", rc2 - rc1); end
    checks++; if (ra1 !== 1'b0 || ra2 !== 1'b0) begin errors++; $display("FAIL b2b_ready_width got %b%b want 00", ra1, ra2); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_wrap();
    test_annul();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for the EX stage.
- It is the responder side of the ALU's divide handshake: the ALU holds start high while stalled and waits for ready; this block computes and returns {remainder, quotient}.
- Handles DIV (signed) and DIVU (unsigned). The result is written into HiLo as Hi = remainder, Lo = quotient.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- signed_div_i  input  1  1 = signed divide, 0 = unsigned; sampled with start_i in IDLE.
- opdata1_i  input  WIDTH  dividend (rs); sampled in IDLE.
- opdata2_i  input  WIDTH  divisor (rt); sampled in IDLE.
- start_i  input  1  request; held high by the initiator until ready_o is seen.
- annul_i  input  1  cancel (pipeline or exception flush).
- result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  one-cycle pulse; result_o is valid in that cycle.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. rst and annul_i are both synchronous.
- Reset: state = IDLE, result_o = 0, ready_o = 0, counter = 0.
- States: IDLE, ZERO, CALC, DONE. Encodings live in defines2.vh.

State transitions:
- IDLE with start_i = 1 and annul_i = 0:
  - Latch operand magnitudes (absolute values only if signed_div_i = 1).
  - Latch the sign flags and signed_div_i.
  - If divisor = 0, go to ZERO; otherwise go to CALC with counter = 0.
- IDLE with start_i = 0: stay in IDLE; result_o holds its last value.
- ZERO: next state DONE, result_o = 0. Divide by zero is UNPREDICTABLE in MIPS; the block defines the result as 0.
- CALC, per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor; if no borrow, keep the difference and set quotient bit = 1.
  - Increment counter.
- CALC exit: on the cycle counter = WIDTH-1, perform sign fix-up, register result_o, and go to DONE.
- DONE: ready_o = 1 for exactly this cycle; next state IDLE. start_i is ignored in DONE; the initiator drops it in the same cycle it sees ready.

Latency:
- start accepted at cycle t: ready_o at t+33 (1 + 32 CALC cycles), or at t+2 for a zero divisor.
- Back-to-back: a new start is accepted in the IDLE cycle that follows DONE.

Sign rules (signed mode only):
- Quotient is negated if dividend sign XOR divisor sign.
- Remainder takes the sign of the dividend.
- Magnitudes use WIDTH-bit two's-complement negation, so 0x80000000 maps to 0x80000000 treated as unsigned.
- Required wrap: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.

Arithmetic:
- Partial remainder register is WIDTH+1 bits so the borrow is explicit.
- No overflow flag is produced.

Annul and abort:
- annul_i = 1 in any state: next state IDLE, ready_o = 0 next cycle, result_o unchanged.
- annul_i has priority over start_i in the same cycle.
- start_i falling in CALC or ZERO without annul is also an abort to IDLE; the initiator never does this legally, but the behaviour is defined.
- rst has priority over everything.

ready_o rules:
- ready_o is registered (decoded from state DONE); there is no combinational path from inputs.
- ready_o never asserts two consecutive cycles.

Decomposition:
- defines2.vh:
  - State encodings: DIV_IDLE, DIV_ZERO, DIV_CALC, DIV_DONE.
  - Constant DIV_CYCLES = 32.
- One natural sub-module, div_step (combinational):
  - Inputs: partial remainder and divisor.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once in div_iter.

Test Plan:
- Unsigned: 100 / 7, start held. Ready exactly 33 cycles after start; result_o = {0x00000002, 0x0000000E}; ready high for 1 cycle.
- Signed: 0xFFFFFFF9 / 0x00000002 (-7 / 2). Result {0xFFFFFFFF, 0xFFFFFFFD} (r = -1, q = -3).
- Signed and unsigned with the same operands:
  - 0x80000000 / 0xFFFFFFFF signed gives {0x00000000, 0x80000000}.
  - The same operands unsigned give {0x80000000, 0x00000000}.
- Divisor 0: ready 2 cycles after start; result_o = 0.
- Annul 10 cycles into CALC:
  - No ready pulse; state IDLE next cycle; result_o keeps its previous value.
  - An immediate new start of 9 / 3 returns {0, 3} at +33.
- rst asserted mid-CALC:
  - All outputs 0 next cycle; no ready.
  - Back-to-back 20/6 then 21/6 (start re-raised in the IDLE cycle after DONE) gives {2, 3} and then {3, 3}, 34 cycles apart.
